// File: rtl/pulse_cmd_pkg.sv
// pulse_cmd_pkg: opcodes, command word layout and packer state shared with the pulse generator
package pulse_cmd_pkg;
    localparam logic [7:0] CMD_RESET_CLOCK      = 8'd0;
    localparam logic [7:0] CMD_SEND_PULSE       = 8'd1;
    localparam logic [7:0] CMD_SET_PERIOD       = 8'd2;
    localparam logic [7:0] CMD_SET_PHASE_MEAS   = 8'd3;
    localparam logic [7:0] CMD_RESET_PHASE_MEAS = 8'd4;
    localparam int         CMD_MAX              = 4;
    localparam int CMD_MSB = 31, CMD_LSB = 24;
    localparam int COARSE_MSB = 23, COARSE_LSB = 8;
    localparam int FINE_MSB = 7, FINE_LSB = 0;
    typedef struct packed {
        logic [7:0]  cmd;
        logic [15:0] coarse;
        logic [7:0]  fine;
    } cmd_word_t;
    typedef enum logic {ST_COLLECT, ST_HOLD} pack_state_t;
endpackage

// File: rtl/cmd_timeout_timer.sv
// cmd_timeout_timer: counts idle cycles while enabled and pulses expire_o on the last allowed one
module cmd_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] timer_q, timer_d;
    // a clear (byte accepted) in the expiry cycle suppresses the expiry
    always_comb begin
        expire_o = en_i && !clr_i && timer_q == TIMER_LAST;
        timer_d  = (clr_i || expire_o) ? '0 : en_i ? timer_q + 1'b1 : timer_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) timer_q <= '0;
        else      timer_q <= timer_d;
    end
endmodule

// File: rtl/pulse_cmd_packer.sv
// pulse_cmd_packer: packs host bytes into 32-bit command words and writes them to the command FIFO
module pulse_cmd_packer
    import pulse_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 16,
    parameter int MAX_CMD        = CMD_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_byte_data,
    input  logic             s_byte_valid,
    output logic             s_byte_ready,
    input  logic             fifo_full,
    output logic [31:0]      fifo_data,
    output logic             fifo_write,
    input  logic             cnt_clr,
    output logic             busy,
    output logic [CNT_W-1:0] words_written,
    output logic [CNT_W-1:0] err_bad_cmd,
    output logic [CNT_W-1:0] err_timeout
);
    pack_state_t state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [31:0] shreg_q, shreg_d, data_q, data_d;
    logic write_q, write_d;
    logic [CNT_W-1:0] words_q, words_d, bad_q, bad_d, tout_q, tout_d;
    logic accept, last, bad, timeout;
    cmd_word_t word;
    cmd_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (accept),
        .en_i     (state_q == ST_COLLECT && idx_q != 2'd0),
        .expire_o (timeout)
    );
    always_comb begin
        accept  = s_byte_valid && state_q == ST_COLLECT;
        last    = accept && idx_q == 2'd3;
        shreg_d = shreg_q;
        if (accept) shreg_d[{~idx_q, 3'b000} +: 8] = s_byte_data;
        word    = shreg_d;
        bad     = word.cmd > 8'(MAX_CMD);
        // HOLD keeps the latched word in shreg until the FIFO has room
        write_d = (state_q == ST_HOLD || (last && !bad)) && !fifo_full;
        state_d = write_d ? ST_COLLECT : (last && !bad) ? ST_HOLD : state_q;
        data_d  = write_d ? shreg_d : data_q;
        idx_d   = timeout ? 2'd0 : accept ? idx_q + 2'd1 : idx_q;
        words_d = cnt_clr ? '0 : (write_d && !(&words_q)) ? words_q + 1'b1 : words_q;
        bad_d   = cnt_clr ? '0 : (last && bad && !(&bad_q)) ? bad_q + 1'b1 : bad_q;
        tout_d  = cnt_clr ? '0 : (timeout && !(&tout_q)) ? tout_q + 1'b1 : tout_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_COLLECT;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
            words_q <= '0;
            bad_q   <= '0;
            tout_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            write_q <= write_d;
            words_q <= words_d;
            bad_q   <= bad_d;
            tout_q  <= tout_d;
        end
    end
    assign s_byte_ready  = state_q == ST_COLLECT;
    assign busy          = idx_q != 2'd0 || state_q == ST_HOLD;
    assign fifo_data     = data_q;
    assign fifo_write    = write_q;
    assign words_written = words_q;
    assign err_bad_cmd   = bad_q;
    assign err_timeout   = tout_q;
endmodule

// File: tb/tb_pulse_cmd_packer.sv
// tb_pulse_cmd_packer: directed and randomized checks of pulse_cmd_packer against a queue-based model
module tb_pulse_cmd_packer;
    localparam int TO = 16, CW = 8, MAXC = (1 << CW) - 1, MAXOP = 4;
    logic clk = 0, rst = 0, s_byte_valid = 0, fifo_full = 0, cnt_clr = 0;
    logic [7:0] s_byte_data = 0;
    logic s_byte_ready, fifo_write, busy;
    logic [31:0] fifo_data;
    logic [CW-1:0] words_written, err_bad_cmd, err_timeout;
    int vectors = 0, miscompares = 0, nwr = 0;

    pulse_cmd_packer #(.TIMEOUT_CYCLES(TO), .CNT_W(CW), .MAX_CMD(MAXOP)) dut (
        .clk(clk), .rst(rst), .s_byte_data(s_byte_data), .s_byte_valid(s_byte_valid),
        .s_byte_ready(s_byte_ready), .fifo_full(fifo_full), .fifo_data(fifo_data),
        .fifo_write(fifo_write), .cnt_clr(cnt_clr), .busy(busy), .words_written(words_written),
        .err_bad_cmd(err_bad_cmd), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: bytes of the partial word, idle count, pending word, expected outputs
    byte unsigned part[$];
    int idle = 0, m_words = 0, m_bad = 0, m_tout = 0;
    logic pend = 0, m_write = 0;
    logic [31:0] pword = 0, m_data = 0, w;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            part.delete(); idle = 0; pend = 0; pword = 0; m_data = 0; m_write = 0;
            m_words = 0; m_bad = 0; m_tout = 0;
        end else begin
            m_write = 0;
            if (pend) begin
                if (!fifo_full) begin pend = 0; m_write = 1; m_data = pword; end
            end else if (s_byte_valid) begin
                part.push_back(s_byte_data);
                idle = 0;
                if (part.size() == 4) begin
                    w = {part[0], part[1], part[2], part[3]};
                    part.delete();
                    if (w[31:24] > MAXOP) begin if (m_bad < MAXC) m_bad++; end
                    else if (!fifo_full) begin m_write = 1; m_data = w; end
                    else begin pend = 1; pword = w; end
                end
            end else if (part.size() > 0) begin
                idle++;
                if (idle == TO) begin part.delete(); idle = 0; if (m_tout < MAXC) m_tout++; end
            end
            if (m_write && m_words < MAXC) m_words++;
            if (cnt_clr) begin m_words = 0; m_bad = 0; m_tout = 0; end
        end
    end

    always @(negedge clk) if (rst) begin
        chk("ready", {31'd0, s_byte_ready}, {31'd0, !pend});
        chk("write", {31'd0, fifo_write}, {31'd0, m_write});
        chk("data", fifo_data, m_data);
        chk("busy", {31'd0, busy}, {31'd0, part.size() > 0 || pend});
        chk("words_written", 32'(words_written), 32'(m_words));
        chk("err_bad_cmd", 32'(err_bad_cmd), 32'(m_bad));
        chk("err_timeout", 32'(err_timeout), 32'(m_tout));
        if (fifo_write) nwr++;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b);
        bit r;
        int k;
        k = 0;
        s_byte_valid = 1;
        s_byte_data = b;
        do begin r = s_byte_ready; tick(1); k++; end while (!r && k < 200);
        s_byte_valid = 0;
        if (!r) begin
            vectors++; miscompares++;
            $display("FAIL send: byte %h not accepted within 200 cycles", b);
        end
    endtask

    task automatic send4(input logic [31:0] v);
        for (int i = 3; i >= 0; i--) send(v[8*i +: 8]);
    endtask

    initial begin
        int base;
        tick(3);
        chk("rst_write", {31'd0, fifo_write}, 0);
        chk("rst_data", fifo_data, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_words", 32'(words_written), 0);
        rst = 1;
        tick(1);
        chk("ready_after_reset", {31'd0, s_byte_ready}, 1);
        base = nwr; send4(32'h01000503); tick(2);
        chk("t1_writes", nwr - base, 1);
        chk("t1_data", fifo_data, 32'h01000503);
        chk("t1_words", 32'(words_written), 1);
        chk("t1_model_words", m_words, 1);
        base = nwr; send4(32'h07000000); tick(2);
        chk("t2_bad", 32'(err_bad_cmd), 1);
        chk("t2_model_bad", m_bad, 1);
        chk("t2_nowrite", nwr - base, 0);
        send4(32'h02000010); tick(2);
        chk("t2_data", fifo_data, 32'h02000010);
        fifo_full = 1; base = nwr; send4(32'h00000000);
        chk("t3_ready_low", {31'd0, s_byte_ready}, 0);
        tick(20);
        chk("t3_still_held", {31'd0, s_byte_ready}, 0);
        chk("t3_nowrite", nwr - base, 0);
        chk("t3_busy", {31'd0, busy}, 1);
        fifo_full = 0; tick(1);
        chk("t3_write", {31'd0, fifo_write}, 1);
        chk("t3_ready_back", {31'd0, s_byte_ready}, 1);
        chk("t3_words", 32'(words_written), 3);
        send(8'h01); send(8'hAA); tick(15);
        chk("t4_busy_before", {31'd0, busy}, 1);
        chk("t4_tout_before", 32'(err_timeout), 0);
        tick(1);
        chk("t4_tout", 32'(err_timeout), 1);
        chk("t4_model_tout", m_tout, 1);
        chk("t4_busy_after", {31'd0, busy}, 0);
        send4(32'h01000002); tick(2);
        chk("t4_data", fifo_data, 32'h01000002);
        send(8'h01); send(8'hAA); tick(15); send(8'h00);
        chk("t4_edge_tout", 32'(err_timeout), 1);
        chk("t4_edge_busy", {31'd0, busy}, 1);
        send(8'h05); tick(2);
        chk("t4_edge_data", fifo_data, 32'h01AA0005);
        send(8'h03); send(8'h01);
        rst = 0; #2;
        chk("t5_data", fifo_data, 0);
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_words", 32'(words_written), 0);
        chk("t5_tout", 32'(err_timeout), 0);
        tick(2); rst = 1; tick(1);
        send4(32'h04000000); tick(2);
        chk("t5_after_data", fifo_data, 32'h04000000);
        chk("t5_after_words", 32'(words_written), 1);
        for (int i = 0; i < MAXC + 5; i++) send4({8'($urandom_range(MAXOP + 1, 255)), 24'($urandom)});
        tick(1);
        chk("t6_sat", 32'(err_bad_cmd), MAXC);
        chk("t6_model_sat", m_bad, MAXC);
        send(8'hFF); send(8'h00); send(8'h00);
        cnt_clr = 1; send(8'h00); cnt_clr = 0;
        chk("t6_clr_bad", 32'(err_bad_cmd), 0);
        chk("t6_clr_words", 32'(words_written), 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) begin s_byte_valid = 0; tick(20); end
            s_byte_valid = $urandom_range(0, 9) < 7;
            s_byte_data = $urandom_range(0, 1) ? 8'($urandom_range(0, 5)) : 8'($urandom);
            fifo_full = $urandom_range(0, 9) < 3;
            cnt_clr = $urandom_range(0, 299) == 0;
            tick(1);
        end
        s_byte_valid = 0; fifo_full = 0; cnt_clr = 0;
        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
